// File: rtl/button_arbiter_if.sv
// rtl/button_arbiter_if.sv - button/command signal bundle between button hardware and the arbiter
//
// Purpose: groups the raw push-button levels and the arbiter's command outputs.
// Signals:
//   BTNL_IN, BTNC_IN, BTNR_IN : raw asynchronous push-button levels (into the arbiter)
//   BTNL, BTNC, BTNR          : single-cycle, mutually exclusive command pulses
//   BUSY                      : high while a grant or lockout is in progress
//   DROPPED                   : single-cycle pulse when simultaneous presses were discarded
// Modports: master drives the raw levels and observes the commands; slave is the arbiter.
interface button_arbiter_if;
    logic BTNL_IN;
    logic BTNC_IN;
    logic BTNR_IN;
    logic BTNL;
    logic BTNC;
    logic BTNR;
    logic BUSY;
    logic DROPPED;

    modport master (
        output BTNL_IN, BTNC_IN, BTNR_IN,
        input  BTNL, BTNC, BTNR, BUSY, DROPPED
    );

    modport slave (
        input  BTNL_IN, BTNC_IN, BTNR_IN,
        output BTNL, BTNC, BTNR, BUSY, DROPPED
    );
endinterface

// File: rtl/button_arbiter.sv
// rtl/button_arbiter.sv - debounced three-button arbiter issuing one command pulse per press
//
// Purpose: synchronizes and debounces three push-buttons, captures new presses while
// idle, grants exactly one of them per press episode and then locks out until every
// button has been released.
// Ports:
//   CLK   : system clock, all logic on the rising edge
//   RESET : synchronous, active-high reset
//   bus   : button_arbiter_if.slave (raw button levels in, command pulses/BUSY/DROPPED out)
// Parameter:
//   DEBOUNCE_COUNT : consecutive stable cycles before a level change is accepted (1 .. 2^20-1)
// Configuration macro:
//   ARB_ROUND_ROBIN_EN : when defined, round-robin winner selection starting at a rotating
//                        pointer; when undefined, fixed priority L > C > R.
module button_arbiter #(
    parameter int DEBOUNCE_COUNT = 1000000
) (
    input  logic             CLK,
    input  logic             RESET,
    button_arbiter_if.slave  bus
);

    localparam logic [19:0] C_LIMIT = 20'(DEBOUNCE_COUNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Bit order everywhere: [0]=L, [1]=C, [2]=R
    logic [2:0]  w_raw;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [19:0] r_cnt [3];
    logic [2:0]  r_deb;
    logic [2:0]  r_deb_prev;
    logic [2:0]  r_pend;
    logic [2:0]  r_winner;
    logic [2:0]  w_rise;
    logic [2:0]  w_winner;
    logic [2:0]  w_btn;
    logic        w_busy;
    logic        w_dropped;
    logic        w_multi;
    state_t      r_state;
    state_t      w_next;

    assign w_raw = {bus.BTNR_IN, bus.BTNC_IN, bus.BTNL_IN};

    // Two-flop synchronizer, then a per-button stability counter that only runs while
    // the synchronized level disagrees with the accepted (debounced) level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1    <= 3'b000;
            r_sync2    <= 3'b000;
            r_deb      <= 3'b000;
            r_deb_prev <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= 20'd0;
            end
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= 20'd0;
                end else if (r_cnt[i] == C_LIMIT) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= 20'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 20'd1;
                end
            end
        end
    end

    assign w_rise  = r_deb & ~r_deb_prev;
    assign w_multi = (r_pend[0] & r_pend[1]) | (r_pend[0] & r_pend[2]) | (r_pend[1] & r_pend[2]);

`ifdef ARB_ROUND_ROBIN_EN
    // Index (0..2) of the button searched first.
    logic [1:0] r_ptr;

    always_comb begin
        int  v_idx;
        logic v_found;
        w_winner = 3'b000;
        v_found  = 1'b0;
        v_idx    = 0;
        for (int k = 0; k < 3; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= 3) begin
                v_idx = v_idx - 3;
            end
            if (!v_found && r_pend[v_idx]) begin
                w_winner[v_idx] = 1'b1;
                v_found         = 1'b1;
            end
        end
    end

    // Pointer advances to the button after the winner, at the moment the winner is latched.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ptr <= 2'd0;
        end else if (r_state == S_IDLE && |r_pend) begin
            if (w_winner[0]) begin
                r_ptr <= 2'd1;
            end else if (w_winner[1]) begin
                r_ptr <= 2'd2;
            end else begin
                r_ptr <= 2'd0;
            end
        end
    end
`else
    always_comb begin
        w_winner = 3'b000;
        if (r_pend[0]) begin
            w_winner = 3'b001;
        end else if (r_pend[1]) begin
            w_winner = 3'b010;
        end else if (r_pend[2]) begin
            w_winner = 3'b100;
        end
    end
`endif

    // Pending flags collect new presses only while idle; GRANT consumes all of them.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pend   <= 3'b000;
            r_winner <= 3'b000;
        end else begin
            if (r_state == S_GRANT) begin
                r_pend <= 3'b000;
            end else if (r_state == S_IDLE) begin
                r_pend <= r_pend | w_rise;
            end
            if (r_state == S_IDLE && |r_pend) begin
                r_winner <= w_winner;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_btn     = 3'b000;
        w_busy    = 1'b0;
        w_dropped = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_next = S_GRANT;
                end
            end
            S_GRANT: begin
                w_btn     = r_winner;
                w_busy    = 1'b1;
                w_dropped = w_multi;
                w_next    = S_HOLD;
            end
            S_HOLD: begin
                w_busy = 1'b1;
                if (r_deb == 3'b000) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.BTNL    = w_btn[0];
    assign bus.BTNC    = w_btn[1];
    assign bus.BTNR    = w_btn[2];
    assign bus.BUSY    = w_busy;
    assign bus.DROPPED = w_dropped;

endmodule

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 Parameter DEBOUNCE_COUNT, default 1000000, means the consecutive stable cycles required before a level change is accepted (range 1 to 2^20-1).
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 BTNL_IN, BTNC_IN, BTNR_IN  input  1 each  raw asynchronous push-button levels.
REQ-005 BTNL, BTNC, BTNR  output  1 each  single-cycle command pulses to the button-driven state machine.
REQ-006 BUSY  output  1  high while a grant or lockout is in progress.
REQ-007 DROPPED  output  1  single-cycle pulse when one or more simultaneous presses are discarded.

Function
REQ-008 Each raw input SHALL pass through a 2-flop synchronizer.
REQ-009 Each button SHALL have a debounced level (reset 0) and a 20-bit counter, counter cleared whenever synchronized value equals debounced level.
REQ-010 Debounced level SHALL toggle, and its counter clear, when the counter reaches DEBOUNCE_COUNT with the synchronized value still differing.
REQ-011 A 0->1 transition of a debounced level SHALL set that button's pending flag only while the FSM is IDLE.
REQ-012 FSM states: IDLE, GRANT, HOLD; reset state IDLE.
REQ-013 IDLE -> GRANT when any pending flag is set, latching one winner; otherwise stay IDLE.
REQ-014 GRANT (one cycle): assert the winner's output pulse; clear all pending flags; pulse DROPPED if more than one flag was pending; go to HOLD.
REQ-015 HOLD: stay until all three debounced levels are 0, then go to IDLE; presses during GRANT/HOLD are ignored.
REQ-016 BTNL/BTNC/BTNR SHALL be mutually exclusive (at most one high in any cycle) and high for exactly one cycle per grant.
REQ-017 BUSY = 1 in GRANT and HOLD, 0 in IDLE.
REQ-018 Latency: a raw input held high from edge 0 SHALL produce its output pulse in the cycle after edge DEBOUNCE_COUNT+4, with the FSM IDLE and no other buttons active.
REQ-019 Glitches shorter than DEBOUNCE_COUNT cycles SHALL produce no pulse and no pending flag.

Reset
REQ-020 RESET SHALL, on the next rising edge, clear synchronizers, counters, debounced levels, pending flags and the round-robin pointer (to L), force IDLE, and drive BTNL, BTNC, BTNR, BUSY and DROPPED to 0.
REQ-021 RESET asserted in GRANT SHALL suppress that cycle's pulse being re-issued; no pulse SHALL occur after reset until a fresh debounced press.
REQ-022 A button held through RESET deassertion SHALL register as a new press after DEBOUNCE_COUNT+4 cycles.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN selects the winner policy.
REQ-024 Without ARB_ROUND_ROBIN_EN: fixed priority L > C > R.
REQ-025 With ARB_ROUND_ROBIN_EN: search order L->C->R starting at a pointer (reset L); after each grant the pointer moves to the button following the winner (R wraps to L).

Verification
REQ-026 DEBOUNCE_COUNT=4; BTNC_IN high 20 cycles -> one BTNC pulse exactly 8 cycles after first high sample, BUSY high until release debounced.
REQ-027 DEBOUNCE_COUNT=4; BTNR_IN 3-cycle glitch -> no output pulse, BUSY stays 0.
REQ-028 Fixed priority; L,C,R pressed same cycle -> single BTNL pulse, DROPPED pulse same cycle; repeat -> BTNL again.
REQ-029 ARB_ROUND_ROBIN_EN; L,C,R pressed together three times (released between) -> BTNL, then BTNC, then BTNR.
REQ-030 BTNL held, BTNR pressed during HOLD -> no BTNR pulse; both released then BTNR pressed -> one BTNR pulse.
REQ-031 RESET asserted during HOLD with button held -> outputs 0, IDLE next edge; button still held -> new pulse DEBOUNCE_COUNT+4 cycles after RESET deasserts.
